if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 127 ++++++++++++
 tb/tb_if_fetch_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and registers the fetched word.
// Optional IF_EARLY_JUMP_EN: resolve j/jal targets in the fetch cycle instead of waiting for a redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] inst,
    output logic [31:0] addr,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        halted,
    output logic        addr_err
);

    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS) << 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic        r_if_valid;
    logic        r_halted;
    logic        r_addr_err;

    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic [31:0] w_redirect_tgt;
    logic        w_pc_in_range;
    logic        w_tgt_in_range;

    assign w_pc4          = r_pc + 32'd4;
    assign w_redirect_tgt = redirect_pc & ~32'd3;
    assign w_pc_in_range  = (r_pc < ROM_BYTES);
    assign w_tgt_in_range = (w_redirect_tgt < ROM_BYTES);

    always_comb begin
        w_next_pc = w_pc4;
`ifdef IF_EARLY_JUMP_EN
        if (inst[31:26] == 6'b000010 || inst[31:26] == 6'b000011) begin
            w_next_pc = {w_pc4[31:28], inst[25:0], 2'b00};
        end
`else
        w_next_pc = w_pc4;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_if_inst  <= '0;
            r_if_pc    <= '0;
            r_if_pc4   <= '0;
            r_if_valid <= 1'b0;
            r_halted   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_if_valid <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Redirect flushes even under stall; the range check only runs on a fetch that would capture.
                    if (redirect) begin
                        r_pc       <= w_redirect_tgt;
                        r_if_valid <= 1'b0;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (!w_pc_in_range) begin
                        r_addr_err <= 1'b1;
                        r_if_valid <= 1'b0;
                        r_halted   <= 1'b1;
                        r_state    <= S_HALT;
                    end else begin
                        r_if_inst  <= inst;
                        r_if_pc    <= r_pc;
                        r_if_pc4   <= w_pc4;
                        r_if_valid <= 1'b1;
                        r_pc       <= w_next_pc;
                    end
                end
                S_HALT: begin
                    r_if_valid <= 1'b0;
                    if (redirect) begin
                        r_pc <= w_redirect_tgt;
                        if (w_tgt_in_range) begin
                            r_halted <= 1'b0;
                            r_state  <= S_RUN;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_if_valid <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign addr     = r_pc;
    assign if_inst  = r_if_inst;
    assign if_pc    = r_if_pc;
    assign if_pc4   = r_if_pc4;
    assign if_valid = r_if_valid;
    assign halted   = r_halted;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a behavioural fetch model predicts post-edge outputs,
// a monitor process compares them after every rising edge.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          ROM_WORDS = 32;
    localparam logic [31:0] ROM_BYTES = 32'd128;

    logic        clk = 1'b1;
    logic        rst;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        halted;
    logic        addr_err;

    logic [31:0] rom [0:ROM_WORDS-1];

    if_fetch_stage #(
        .RESET_PC (RESET_PC),
        .ROM_WORDS(ROM_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst       (inst),
        .addr       (addr),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_pc4     (if_pc4),
        .if_valid   (if_valid),
        .halted     (halted),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    assign inst = (addr < ROM_BYTES) ? rom[addr[6:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    // Behavioural model: fetch machine described as "running / halted / waiting" flags.
    logic [31:0] m_pc, m_inst, m_ipc;
    logic        m_cap, m_valid, m_halted, m_err, m_run;

    function automatic logic [31:0] follow(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] seq;
        seq = pc + 32'd4;
`ifdef IF_EARLY_JUMP_EN
        if (w[31:26] == 6'd2 || w[31:26] == 6'd3) return {seq[31:28], w[25:0], 2'b00};
`endif
        return seq;
    endfunction

    task automatic model_step(input logic r, s, st, rd, input logic [31:0] rpc);
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (r) begin
            m_pc = RESET_PC; m_inst = 0; m_ipc = 0; m_cap = 0;
            m_valid = 0; m_halted = 0; m_err = 0; m_run = 0;
        end else if (m_halted) begin
            if (rd) begin
                m_pc = tgt;
                if (tgt < ROM_BYTES) begin
                    m_halted = 0;
                    m_run = 1;
                end
            end
        end else if (!m_run) begin
            m_valid = 0;
            if (s) m_run = 1;
        end else if (rd) begin
            m_pc = tgt;
            m_valid = 0;
        end else if (!st) begin
            if (m_pc >= ROM_BYTES) begin
                m_err = 1; m_valid = 0; m_halted = 1; m_run = 0;
            end else begin
                m_inst  = rom[m_pc[6:2]];
                m_ipc   = m_pc;
                m_cap   = 1;
                m_valid = 1;
                m_pc    = follow(m_pc, m_inst);
            end
        end
    endtask

    task automatic drive(input logic r, s, st, rd, input logic [31:0] rpc);
        exp_t e;
        @(negedge clk);
        rst = r; start = s; stall = st; redirect = rd; redirect_pc = rpc;
        model_step(r, s, st, rd, rpc);
        e.addr   = m_pc;
        e.inst   = m_inst;
        e.pc     = m_ipc;
        e.pc4    = m_cap ? m_ipc + 32'd4 : 32'd0;
        e.valid  = m_valid;
        e.halted = m_halted;
        e.err    = m_err;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("addr",     addr,             e.addr);
                chk("if_inst",  if_inst,          e.inst);
                chk("if_pc",    if_pc,            e.pc);
                chk("if_pc4",   if_pc4,           e.pc4);
                chk("if_valid", {31'd0, if_valid}, {31'd0, e.valid});
                chk("halted",   {31'd0, halted},   {31'd0, e.halted});
                chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
            end
        end
    end

    initial begin : stimulus
        int n;
        logic [31:0] w;
        rst = 1; start = 0; stall = 0; redirect = 0; redirect_pc = 0;
        for (int i = 0; i < ROM_WORDS; i++) begin
            w = $urandom;
            if (w[31:26] == 6'd2 || w[31:26] == 6'd3) w[31:26] = w[31:26] ^ 6'h10;
            rom[i] = w;
        end
        rom[0] = 32'h0800_0005;
        model_step(1, 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        n = 0;
        while (m_pc != 32'h18 && n < 50) begin drive(0, 0, 0, 0, 0); n++; end
        if (m_pc != 32'h18) begin failed++; $display("FAIL reach_0x18: model pc %h expected 00000018", m_pc); end
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 32'h0000_0006);
        drive(0, 0, 0, 0, 0);

        n = 0;
        while (!m_halted && n < 80) begin drive(0, 0, 0, 0, 0); n++; end
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h0000_0200);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h0000_0014);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);

        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h0000_007D);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            logic r, s, st, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h9F));
            drive(r, s, st, rd, rpc);
        end
        drive(0, 0, 0, 0, 0);

        n = 0;
        while (q.size() != 0 && n < 10) begin @(posedge clk); n++; end
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
